// File: rtl/msm_bucket_sched.sv
`default_nettype none
// ============================================================================
// Module   : msm_bucket_sched
// Purpose  : Issue scheduler in front of the MSM bucket controller. Merges the
//            point stream and the PADD result stream, avoids bucket-id
//            collisions and stale-flag hazards, buffers deferred points in a
//            small replay FIFO, tracks in-flight PADDs and flags batch done.
// Options  : SCHED_STATS_EN adds stall_cnt / conflict_cnt statistics outputs.
// Revision : 1.0 - initial release
// ============================================================================
module msm_bucket_sched #(
  parameter int WIDTH_ID   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CNT_W-1:0]         n_points,
  input  logic                     pm_valid,
  input  logic [WIDTH_ID-1:0]      pm_id,
  output logic                     pm_ready,
  input  logic                     rb_valid,
  input  logic [WIDTH_ID-1:0]      rb_id,
  output logic                     rb_ready,
  input  logic [(1<<WIDTH_ID)-1:0] bucket_flag,
  output logic                     pm_status,
  output logic [WIDTH_ID-1:0]      id_o_pm,
  output logic                     rb_status,
  output logic [WIDTH_ID-1:0]      id_o_rb,
  output logic [CNT_W-1:0]         inflight,
  output logic                     busy,
  output logic                     done,
  output logic                     fifo_ovf
`ifdef SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         conflict_cnt
`endif
);

  localparam int NB = 1 << WIDTH_ID;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]    n_lat;
  logic [CNT_W-1:0]    points_taken;
  logic [WIDTH_ID-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]       rd_ptr, wr_ptr;
  logic [PW:0]         fifo_cnt;

  // Issues from two cycles ago; last cycle's issues are the status outputs.
  logic                h2_pm_v, h2_rb_v;
  logic [WIDTH_ID-1:0] h2_pm_id, h2_rb_id;

  logic [NB-1:0]       hmask;
  logic                fifo_empty, fifo_full;
  logic                pm_acc, rb_acc, rb_flag;
  logic                cand_v, cand_fifo;
  logic [WIDTH_ID-1:0] cand_id;
  logic                same_id, dbl_add, blocked, issue;
  logic                push, pop, inc, dec;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign pm_ready   = (state == S_RUN) && !fifo_full && (points_taken < n_lat);

  // Hazard set, result acceptance and point-candidate arbitration.
  always_comb begin
    hmask = '0;
    if (pm_status) hmask[id_o_pm]  = 1'b1;
    if (rb_status) hmask[id_o_rb]  = 1'b1;
    if (h2_pm_v)   hmask[h2_pm_id] = 1'b1;
    if (h2_rb_v)   hmask[h2_rb_id] = 1'b1;

    rb_ready  = rb_valid && !hmask[rb_id];
    rb_acc    = rb_ready;
    rb_flag   = bucket_flag[rb_id];
    pm_acc    = pm_valid && pm_ready;

    cand_fifo = !fifo_empty;
    cand_v    = cand_fifo || pm_acc;
    cand_id   = cand_fifo ? fifo_mem[rd_ptr] : pm_id;

    same_id   = rb_acc && (cand_id == rb_id);
    dbl_add   = rb_acc && rb_flag && bucket_flag[cand_id];
    blocked   = cand_v && (hmask[cand_id] || same_id || dbl_add);
    issue     = cand_v && !blocked;

    pop       = cand_fifo && issue;
    push      = pm_acc && !(fifo_empty && issue);
    inc       = issue && bucket_flag[cand_id];
    dec       = rb_acc && !rb_flag;
  end

  // Batch sequencing.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (n_points == '0) ? S_DRAIN : S_RUN;
      S_RUN:   if (points_taken == n_lat) state_nx = S_DRAIN;
      S_DRAIN: if (fifo_empty && (inflight == '0) && !rb_valid) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State, batch counters, issue registers and hazard history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      n_lat        <= '0;
      points_taken <= '0;
      pm_status    <= 1'b0;
      id_o_pm      <= '0;
      rb_status    <= 1'b0;
      id_o_rb      <= '0;
      h2_pm_v      <= 1'b0;
      h2_pm_id     <= '0;
      h2_rb_v      <= 1'b0;
      h2_rb_id     <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        n_lat        <= n_points;
        points_taken <= '0;
      end else if (pm_acc) begin
        points_taken <= points_taken + 1'b1;
      end
      pm_status <= issue;
      id_o_pm   <= issue ? cand_id : '0;
      rb_status <= rb_acc;
      id_o_rb   <= rb_acc ? rb_id : '0;
      h2_pm_v   <= pm_status;
      h2_pm_id  <= id_o_pm;
      h2_rb_v   <= rb_status;
      h2_rb_id  <= id_o_rb;
    end
  end

  // Replay FIFO; a push into a full FIFO without a pop is dropped and flagged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      fifo_ovf <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push && fifo_full && !pop) begin
        fifo_ovf <= 1'b1;
      end else if (push) begin
        fifo_mem[wr_ptr] <= pm_id;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if ((push && !(fifo_full && !pop)) && !pop)  fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push)                       fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  // In-flight PADD counter, saturating at both ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (inc && !dec && inflight != CNT_MAX) begin
      inflight <= inflight + 1'b1;
    end else if (dec && !inc && inflight != '0) begin
      inflight <= inflight - 1'b1;
    end
  end

`ifdef SCHED_STATS_EN
  // Saturating stall and same-id collision statistics, cleared on start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt    <= '0;
      conflict_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      stall_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (blocked && stall_cnt != CNT_MAX)               stall_cnt    <= stall_cnt + 1'b1;
      if (cand_v && same_id && conflict_cnt != CNT_MAX)  conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_msm_bucket_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_msm_bucket_sched
// Purpose  : Directed, table-driven self-checking bench for msm_bucket_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msm_bucket_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] n_points;
  logic        pm_valid;
  logic [1:0]  pm_id;
  logic        pm_ready;
  logic        rb_valid;
  logic [1:0]  rb_id;
  logic        rb_ready;
  logic [3:0]  bucket_flag;
  logic        pm_status;
  logic [1:0]  id_o_pm;
  logic        rb_status;
  logic [1:0]  id_o_rb;
  logic [15:0] inflight;
  logic        busy;
  logic        done;
  logic        fifo_ovf;
`ifdef SCHED_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msm_bucket_sched #(.WIDTH_ID(2), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_points(n_points),
    .pm_valid(pm_valid), .pm_id(pm_id), .pm_ready(pm_ready),
    .rb_valid(rb_valid), .rb_id(rb_id), .rb_ready(rb_ready),
    .bucket_flag(bucket_flag),
    .pm_status(pm_status), .id_o_pm(id_o_pm),
    .rb_status(rb_status), .id_o_rb(id_o_rb),
    .inflight(inflight), .busy(busy), .done(done), .fifo_ovf(fifo_ovf)
`ifdef SCHED_STATS_EN
    , .stall_cnt(stall_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  typedef struct {
    logic        start;
    logic [15:0] n;
    logic        pv;
    logic [1:0]  pid;
    logic        rv;
    logic [1:0]  rid;
    logic [3:0]  flg;
    logic        e_prdy, e_rrdy, e_ps;
    logic [1:0]  e_ipm;
    logic        e_rs;
    logic [1:0]  e_irb;
    logic [15:0] e_infl;
    logic        e_busy, e_done;
    int          e_stall, e_conf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int st, n, pv, pid, rv, rid, flg,
                              prdy, rrdy, ps, ipm, rs, irb, infl, bsy, dn,
                              input int stl = -1, cnf = -1);
    vec_t v;
    v.start = st[0]; v.n = n[15:0]; v.pv = pv[0]; v.pid = pid[1:0];
    v.rv = rv[0]; v.rid = rid[1:0]; v.flg = flg[3:0];
    v.e_prdy = prdy[0]; v.e_rrdy = rrdy[0]; v.e_ps = ps[0]; v.e_ipm = ipm[1:0];
    v.e_rs = rs[0]; v.e_irb = irb[1:0]; v.e_infl = infl[15:0];
    v.e_busy = bsy[0]; v.e_done = dn[0]; v.e_stall = stl; v.e_conf = cnf;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input int st, n, pv, pid, rv, rid, flg);
    start = st[0]; n_points = n[15:0]; pm_valid = pv[0]; pm_id = pid[1:0];
    rb_valid = rv[0]; rb_id = rid[1:0]; bucket_flag = flg[3:0];
  endtask

  task automatic cyc(input int st, n, pv, pid, rv, rid, flg);
    drive(st, n, pv, pid, rv, rid, flg);
    @(posedge clk); #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_pm_status"}, -1, pm_status, 0);
    chk({tag, "_id_o_pm"},   -1, id_o_pm, 0);
    chk({tag, "_rb_status"}, -1, rb_status, 0);
    chk({tag, "_id_o_rb"},   -1, id_o_rb, 0);
    chk({tag, "_inflight"},  -1, inflight, 0);
    chk({tag, "_busy"},      -1, busy, 0);
    chk({tag, "_done"},      -1, done, 0);
    chk({tag, "_fifo_ovf"},  -1, fifo_ovf, 0);
    chk({tag, "_pm_ready"},  -1, pm_ready, 0);
    chk({tag, "_rb_ready"},  -1, rb_ready, 0);
  endtask

  initial begin
    bit seen;

    // Batch of 4 distinct ids, no results.
    add(1,4,0,0,0,0,0, 0,0, 0,0,0,0,0, 1,0);
    add(0,0,1,0,0,0,0, 1,0, 1,0,0,0,0, 1,0);
    add(0,0,1,1,0,0,0, 1,0, 1,1,0,0,0, 1,0);
    add(0,0,1,2,0,0,0, 1,0, 1,2,0,0,0, 1,0);
    add(0,0,1,3,0,0,0, 1,0, 1,3,0,0,0, 1,0);
    add(0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 1,0);
    add(0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 1,1);
    add(0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 0,0);
    // Same-id pm/rb collision: rb wins, point replays after leaving H.
    add(1,1,0,0,0,0,0, 0,0, 0,0,0,0,0, 1,0);
    add(0,0,1,1,1,1,0, 1,1, 0,0,1,1,0, 1,0);
    add(0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 1,0);
    add(0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 1,0);
    add(0,0,0,0,0,0,0, 0,0, 1,1,0,0,0, 1,0);
    add(0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 1,1);
    add(0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 0,0, 3,1);
    // Back-to-back id 2: issues 3 cycles apart, FIFO fills, pm_ready drops.
    add(1,8,0,0,0,0,0, 0,0, 0,0,0,0,0, 1,0);
    add(0,0,1,2,0,0,0, 1,0, 1,2,0,0,0, 1,0);
    add(0,0,1,2,0,0,0, 1,0, 0,0,0,0,0, 1,0);
    add(0,0,1,2,0,0,0, 1,0, 0,0,0,0,0, 1,0);
    add(0,0,1,2,0,0,0, 1,0, 1,2,0,0,0, 1,0);
    add(0,0,1,2,0,0,0, 1,0, 0,0,0,0,0, 1,0);
    add(0,0,1,2,0,0,0, 1,0, 0,0,0,0,0, 1,0);
    add(0,0,1,2,0,0,0, 0,0, 1,2,0,0,0, 1,0);
    add(0,0,1,2,0,0,0, 1,0, 0,0,0,0,0, 1,0);
    add(0,0,1,2,0,0,0, 0,0, 0,0,0,0,0, 1,0);
    add(0,0,1,2,0,0,0, 0,0, 1,2,0,0,0, 1,0);
    add(0,0,1,2,0,0,0, 1,0, 0,0,0,0,0, 1,0);
    add(0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 1,0);
    for (int k = 0; k < 3; k++) begin
      add(0,0,0,0,0,0,0, 0,0, 1,2,0,0,0, 1,0);
      add(0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 1,0);
      add(0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 1,0);
    end
    add(0,0,0,0,0,0,0, 0,0, 1,2,0,0,0, 1,0);
    add(0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 1,1);
    add(0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 0,0);
    // Flag on bucket 0: inflight 0 -> 1 -> 0, done only after the rb accept.
    add(1,1,0,0,0,0,0, 0,0, 0,0,0,0,0, 1,0);
    add(0,0,1,0,0,0,1, 1,0, 1,0,0,0,1, 1,0);
    add(0,0,0,0,0,0,1, 0,0, 0,0,0,0,1, 1,0);
    add(0,0,0,0,1,0,0, 0,0, 0,0,0,0,1, 1,0);
    add(0,0,0,0,1,0,0, 0,1, 0,0,1,0,0, 1,0);
    add(0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 1,1);
    add(0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 0,0);
    // Double-add: rb 3 and pm 1 both full, pm deferred one cycle.
    add(1,1,0,0,0,0,0,  0,0, 0,0,0,0,0, 1,0);
    add(0,0,1,1,1,3,10, 1,1, 0,0,1,3,0, 1,0);
    add(0,0,0,0,0,0,10, 0,0, 1,1,0,0,1, 1,0);
    add(0,0,0,0,1,1,0,  0,0, 0,0,0,0,1, 1,0);
    add(0,0,0,0,1,1,0,  0,0, 0,0,0,0,1, 1,0);
    add(0,0,0,0,1,1,0,  0,1, 0,0,1,1,0, 1,0);
    add(0,0,0,0,0,0,0,  0,0, 0,0,0,0,0, 1,1);
    add(0,0,0,0,0,0,0,  0,0, 0,0,0,0,0, 0,0, 1,0);

    // Power-on reset.
    rst_n = 1'b0;
    drive(0,0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].n, vecs[i].pv, vecs[i].pid,
            vecs[i].rv, vecs[i].rid, vecs[i].flg);
      #1;
      chk("pm_ready", i, pm_ready, vecs[i].e_prdy);
      chk("rb_ready", i, rb_ready, vecs[i].e_rrdy);
      @(posedge clk); #1;
      chk("pm_status", i, pm_status, vecs[i].e_ps);
      chk("id_o_pm",   i, id_o_pm,   vecs[i].e_ipm);
      chk("rb_status", i, rb_status, vecs[i].e_rs);
      chk("id_o_rb",   i, id_o_rb,   vecs[i].e_irb);
      chk("inflight",  i, inflight,  vecs[i].e_infl);
      chk("busy",      i, busy,      vecs[i].e_busy);
      chk("done",      i, done,      vecs[i].e_done);
      chk("fifo_ovf",  i, fifo_ovf,  0);
`ifdef SCHED_STATS_EN
      if (vecs[i].e_stall >= 0) begin
        chk("stall_cnt",    i, stall_cnt,    vecs[i].e_stall);
        chk("conflict_cnt", i, conflict_cnt, vecs[i].e_conf);
      end
`endif
    end

    // Mid-batch reset with two FIFO entries and one in-flight PADD.
    cyc(1,4,0,0,0,0,0);
    cyc(0,0,1,2,0,0,4);
    chk("mid_inflight_up", -1, inflight, 1);
    cyc(0,0,1,2,0,0,4);
    cyc(0,0,1,2,0,0,4);
    chk("mid_pm_held", -1, pm_status, 0);
    chk("mid_inflight", -1, inflight, 1);
    rst_n = 1'b0;
    cyc(0,0,0,0,0,0,0);
    chk_idle_outputs("midrst");
    rst_n = 1'b1;
    cyc(0,0,0,0,0,0,0);
    chk("after_rst_busy", -1, busy, 0);

    // Fresh batch after reset: id 3 must issue directly (FIFO cleared).
    cyc(1,1,0,0,0,0,0);
    drive(0,0,1,3,0,0,0);
    #1;
    chk("new_pm_ready", -1, pm_ready, 1);
    @(posedge clk); #1;
    chk("new_pm_status", -1, pm_status, 1);
    chk("new_id_o_pm",   -1, id_o_pm, 3);
    drive(0,0,0,0,0,0,0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("new_batch_done", -1, seen, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
